// File: rtl/stencil_pkg.sv
// Shared geometry defaults, derived-size helpers and the sequencer state type
// for the 2D box stencil tile-run sequencer.
package stencil_pkg;

    localparam int BW_DEFAULT            = 32;
    localparam int ROW_DEFAULT           = 8;
    localparam int COL_DEFAULT           = 8;
    localparam int UNROLL_DEFAULT        = 2;
    localparam int RADIUS_DEFAULT        = 1;
    localparam int POINTS_DEFAULT        = 9;
    localparam int DRAIN_TIMEOUT_DEFAULT = 64;

    // Elements per input beat: the unrolled outputs plus the halo on both sides.
    function automatic int st_of(input int unroll, input int radius);
        return unroll + 2 * radius;
    endfunction

    function automatic int in_words_of(input int row, input int col,
                                       input int unroll, input int radius);
        return row * col / st_of(unroll, radius);
    endfunction

    function automatic int out_words_of(input int row, input int col,
                                        input int unroll, input int radius);
        return (row - 2 * radius) * col / st_of(unroll, radius);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/stencil_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clear has priority over increment.
module stencil_sat_counter #(
    parameter int  MAX = 15,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stencil_run_sequencer.sv
// Runs one tile through the stencil core: issues input-buffer reads, forwards beats
// to the core, captures core outputs into the output buffer, and reports done/timeout.
module stencil_run_sequencer
    import stencil_pkg::*;
#(
    parameter int  BW            = BW_DEFAULT,
    parameter int  ROW           = ROW_DEFAULT,
    parameter int  COL           = COL_DEFAULT,
    parameter int  UNROLL        = UNROLL_DEFAULT,
    parameter int  RADIUS        = RADIUS_DEFAULT,
    parameter int  POINTS        = POINTS_DEFAULT,
    parameter int  DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    localparam int ST            = st_of(UNROLL, RADIUS),
    localparam int IN_WORDS      = in_words_of(ROW, COL, UNROLL, RADIUS),
    localparam int OUT_WORDS     = out_words_of(ROW, COL, UNROLL, RADIUS),
    localparam int RD_AW         = $clog2(IN_WORDS),
    localparam int WR_AW         = $clog2(OUT_WORDS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [POINTS*BW-1:0] cfg_weight,
    input  logic                 src_stall,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 err_overflow,
    output logic                 rd_en,
    output logic [RD_AW-1:0]     rd_addr,
    input  logic [ST*BW-1:0]     rd_data,
    output logic                 io_in_ready,
    output logic [ST*BW-1:0]     io_in_matrix,
    output logic [POINTS*BW-1:0] io_in_weight,
    input  logic                 io_out_valid,
    input  logic [UNROLL*BW-1:0] io_out_data,
    output logic                 wr_en,
    output logic [WR_AW-1:0]     wr_addr,
    output logic [UNROLL*BW-1:0] wr_data
);

    localparam int RC_W = $clog2(IN_WORDS + 1);
    localparam int OC_W = $clog2(OUT_WORDS + 1);
    localparam int IT_W = $clog2(DRAIN_TIMEOUT + 1);

    seq_state_t           state;
    logic [POINTS*BW-1:0] weight;
    logic [RC_W-1:0]      rd_cnt;
    logic [OC_W-1:0]      out_cnt;
    logic [IT_W-1:0]      idle_cnt;
    logic                 rd_at_max, out_at_max, idle_at_max;
    logic                 accept, idle_inc, timeout_hit, drain_fin;

    // A start landing on the done cycle is dropped even though state already reads IDLE.
    assign accept      = start && (state == IDLE) && !done;
    assign rd_en       = (state == ISSUE) && !src_stall && !rd_at_max;
    assign rd_addr     = rd_en ? rd_cnt[RD_AW-1:0] : '0;
    assign wr_en       = (state != IDLE) && io_out_valid && !out_at_max;
    assign wr_addr     = wr_en ? out_cnt[WR_AW-1:0] : '0;
    assign wr_data     = wr_en ? io_out_data : '0;
    assign io_in_matrix = io_in_ready ? rd_data : '0;
    assign io_in_weight = weight;

    assign idle_inc    = (state == DRAIN) && !io_out_valid && !idle_at_max;
    assign timeout_hit = idle_inc && (idle_cnt == IT_W'(DRAIN_TIMEOUT - 1));
    assign drain_fin   = (state == DRAIN) &&
                         (out_at_max || (wr_en && (out_cnt == OC_W'(OUT_WORDS - 1))));

    stencil_sat_counter #(.MAX(IN_WORDS)) u_rd_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .inc   (rd_en),
        .count (rd_cnt),
        .at_max(rd_at_max)
    );

    stencil_sat_counter #(.MAX(OUT_WORDS)) u_out_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .inc   (wr_en),
        .count (out_cnt),
        .at_max(out_at_max)
    );

    stencil_sat_counter #(.MAX(DRAIN_TIMEOUT)) u_idle_cnt (
        .clock (clock),
        .reset (reset),
        .clr   ((state != DRAIN) || io_out_valid),
        .inc   (idle_inc),
        .count (idle_cnt),
        .at_max(idle_at_max)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            io_in_ready  <= 1'b0;
            // NOTE: the wide weight register is reset explicitly so io_in_weight reads 0 after reset.
            weight       <= '0;
        end else begin
            done        <= 1'b0;
            io_in_ready <= rd_en;
            if ((state != IDLE) && io_out_valid && out_at_max) begin
                err_overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        weight       <= cfg_weight;
                        err_timeout  <= 1'b0;
                        err_overflow <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_en && (rd_cnt == RC_W'(IN_WORDS - 1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_fin) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stencil_run_sequencer.sv
// Randomized bench for stencil_run_sequencer: a cycle-level reference model built from
// the run rules (read/write tallies, idle streak, sticky flags) checks every output every cycle.
module tb_stencil_run_sequencer;

    localparam int IN_WORDS  = 16;
    localparam int OUT_WORDS = 12;
    localparam int TIMEOUT   = 64;
    localparam int PH_IDLE   = 0;
    localparam int PH_ISSUE  = 1;
    localparam int PH_DRAIN  = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [287:0] cfg_weight = '0;
    logic         src_stall = 1'b0;
    logic         busy, done, err_timeout, err_overflow;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data = '0;
    logic         io_in_ready;
    logic [127:0] io_in_matrix;
    logic [287:0] io_in_weight;
    logic         io_out_valid = 1'b0;
    logic [63:0]  io_out_data = '0;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [63:0]  wr_data;

    always #5 clock = ~clock;

    stencil_run_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cfg_weight  (cfg_weight),
        .src_stall   (src_stall),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .io_in_ready (io_in_ready),
        .io_in_matrix(io_in_matrix),
        .io_in_weight(io_in_weight),
        .io_out_valid(io_out_valid),
        .io_out_data (io_out_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    int checks   = 0;
    int failures = 0;
    int cur_scen = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s scen=%0d cyc=%0d got=%h expected=%h", tag, cur_scen, cyc, got, exp);
        end
    endtask

    // Input buffer contents and the read the DUT requested on the previous cycle.
    logic [127:0] mem [IN_WORDS];
    logic         buf_hit  = 1'b0;
    logic [3:0]   buf_addr = '0;

    // Reference model: what has happened so far in the current run.
    int           m_phase   = PH_IDLE;
    int           m_reads   = 0;
    int           m_writes  = 0;
    int           m_idle    = 0;
    int           m_pending = -1;
    bit           m_done    = 1'b0;
    bit           m_eto     = 1'b0;
    bit           m_eov     = 1'b0;
    logic [287:0] m_weight  = '0;

    // Core stimulus bookkeeping for the current run.
    int run_age = 0, emitted = 0, cur_nval = 0, cur_vdelay = 0;

    logic         e_rd_en, e_ready, e_wr_en;
    logic [3:0]   e_rd_addr, e_wr_addr;
    logic [127:0] e_matrix;
    logic [63:0]  e_wr_data;

    task automatic model_expect();
        e_rd_en   = (m_phase == PH_ISSUE) && !src_stall && (m_reads < IN_WORDS);
        e_rd_addr = e_rd_en ? m_reads[3:0] : 4'd0;
        e_ready   = (m_pending >= 0);
        e_matrix  = e_ready ? mem[m_pending] : 128'd0;
        e_wr_en   = (m_phase != PH_IDLE) && io_out_valid && (m_writes < OUT_WORDS);
        e_wr_addr = e_wr_en ? m_writes[3:0] : 4'd0;
        e_wr_data = e_wr_en ? io_out_data : 64'd0;
    endtask

    task automatic compare_all();
        check("busy", busy, m_phase != PH_IDLE);
        check("done", done, m_done);
        check("err_timeout", err_timeout, m_eto);
        check("err_overflow", err_overflow, m_eov);
        check("rd_en", rd_en, e_rd_en);
        check("rd_addr", rd_addr, e_rd_addr);
        check("io_in_ready", io_in_ready, e_ready);
        check("io_in_matrix", io_in_matrix, e_matrix);
        check("io_in_weight", io_in_weight, m_weight);
        check("wr_en", wr_en, e_wr_en);
        check("wr_addr", wr_addr, e_wr_addr);
        check("wr_data", wr_data, e_wr_data);
    endtask

    task automatic set_run_profile();
        case (cur_scen)
            3:       begin cur_nval = 7;  cur_vdelay = 14; end
            4:       begin cur_nval = 13; cur_vdelay = 1;  end
            7:       begin cur_nval = int'($urandom_range(10, 13)); cur_vdelay = int'($urandom_range(1, 6)); end
            default: begin cur_nval = 12; cur_vdelay = 4;  end
        endcase
    endtask

    // Advance the model across the clock edge that ends the current cycle.
    task automatic model_advance();
        bit was_done;
        int nxt_pending;
        nxt_pending = e_rd_en ? m_reads : -1;
        run_age++;
        if (!reset) begin
            m_phase = PH_IDLE; m_reads = 0; m_writes = 0; m_idle = 0; m_pending = -1;
            m_done = 1'b0; m_eto = 1'b0; m_eov = 1'b0; m_weight = '0;
        end else begin
            was_done  = m_done;
            m_done    = 1'b0;
            m_pending = nxt_pending;
            if (m_phase == PH_IDLE) begin
                if (start && !was_done) begin
                    m_weight = cfg_weight; m_eto = 1'b0; m_eov = 1'b0;
                    m_reads = 0; m_writes = 0; m_idle = 0; m_phase = PH_ISSUE;
                    run_age = 0; emitted = 0;
                    set_run_profile();
                end
            end else begin
                if (io_out_valid && m_writes == OUT_WORDS) m_eov = 1'b1;
                if (e_wr_en) m_writes++;
                if (m_phase == PH_ISSUE) begin
                    if (e_rd_en) m_reads++;
                    if (m_reads == IN_WORDS) begin
                        m_phase = PH_DRAIN;
                        m_idle  = 0;
                    end
                end else if (m_writes == OUT_WORDS) begin
                    m_phase = PH_IDLE; m_done = 1'b1;
                end else begin
                    m_idle = io_out_valid ? 0 : m_idle + 1;
                    if (m_idle == TIMEOUT) begin
                        m_phase = PH_IDLE; m_done = 1'b1; m_eto = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic run(input int scen, input int ncyc, input int want_done, input int want_wr);
        int obs_done = 0, obs_wr = 0, exp_done = 0, exp_wr = 0;
        int lastv_cyc = -1000, done_cyc = -1;
        int first_rdy = -1, last_rdy = -1, rdy_beats = 0;
        cur_scen = scen;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clock);
            #1;
            cyc++;
            reset = !(scen == 6 && k == 10);
            case (scen)
                5:       start = (k == 0) || (k == 5) || (k == 50) || m_done;
                6:       start = (k == 0) || (k == 15);
                7:       start = ($urandom_range(0, 7) == 0);
                default: start = (k == 0);
            endcase
            case (scen)
                2:       src_stall = (k >= 7) && (k <= 9);
                7:       src_stall = ($urandom_range(0, 3) == 0);
                default: src_stall = 1'b0;
            endcase
            for (int i = 0; i < 9; i++) cfg_weight[i*32 +: 32] = $urandom;
            io_out_data  = {$urandom, $urandom};
            io_out_valid = (run_age >= cur_vdelay) && (emitted < cur_nval) &&
                           (scen == 4 || $urandom_range(0, 3) != 0);
            if (io_out_valid) emitted++;
            rd_data = buf_hit ? mem[buf_addr] : {$urandom, $urandom, $urandom, $urandom};
            model_expect();
            @(negedge clock);
            compare_all();
            buf_hit  = rd_en;
            buf_addr = rd_addr;
            if (done) obs_done++;
            if (wr_en) obs_wr++;
            if (m_done) exp_done++;
            if (e_wr_en) exp_wr++;
            if (io_out_valid) lastv_cyc = k;
            if (done && done_cyc < 0) done_cyc = k;
            if (io_in_ready) begin
                if (first_rdy < 0) first_rdy = k;
                last_rdy = k;
                rdy_beats++;
            end
            model_advance();
        end
        check("done_count_model", obs_done, exp_done);
        check("write_count_model", obs_wr, exp_wr);
        if (want_done >= 0) check("done_count", obs_done, want_done);
        if (want_wr >= 0) check("write_count", obs_wr, want_wr);
        if (scen == 2) begin
            check("ready_beats", rdy_beats, IN_WORDS);
            check("ready_gap_cycles", last_rdy - first_rdy + 1 - rdy_beats, 3);
        end
        if (scen == 3) check("timeout_latency", done_cyc - lastv_cyc, TIMEOUT + 1);
    endtask

    initial begin
        for (int i = 0; i < IN_WORDS; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        reset = 1'b0;
        repeat (2) @(posedge clock);
        run(1, 60, 1, 12);
        run(2, 60, 1, 12);
        run(3, 130, 1, 7);
        run(4, 40, 1, 12);
        run(5, 100, 2, 24);
        run(6, 70, 1, -1);
        run(7, 400, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
